sr_latch_writer: RTL and testbench
==================================

Name: sr_latch_writer

Overview:
Write-side controller for a bank of WIDTH enabled SR latches built from NAND gates. It accepts a word-write request through a ready/valid handshake and converts it into timed enable, set and reset pulses. After the pulse it lets the latches settle, then reads back Q/notQ to verify the stored value. It sits between synchronous logic and the latch storage array, and is the only agent driving the latch inputs.

Parameters:
WIDTH, 8, number of latch bits driven and verified
PULSE_CYCLES, 2, clocks the latch enable/set/reset are held active (min 1)
SETTLE_CYCLES, 1, idle clocks between pulse end and readback (0 allowed; the SETTLE state is skipped)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_req  input  1  write request (valid)
wr_data  input  WIDTH  value to store
wr_mask  input  WIDTH  1 = drive and verify this bit; 0 = leave the latch untouched
wr_ready  output  1  high only in IDLE; a write is accepted on a rising edge with wr_req & wr_ready
latch_en  output  1  enable to all latches
latch_set  output  WIDTH  per-bit set
latch_reset  output  WIDTH  per-bit reset
latch_q  input  WIDTH  readback Q
latch_notq  input  WIDTH  readback notQ
done  output  1  one-cycle pulse when a write completes
err  output  1  valid with done; 1 = at least one masked bit failed verification
err_bits  output  WIDTH  valid with done; per-bit failure flags

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; data/mask registers and the counter cleared.
  - latch_en=0, latch_set=0, latch_reset=0, done=0, err=0, err_bits=0.
  - wr_ready=1 once rst_n=1.
  - Reset mid-operation aborts immediately with no further pulses; the latch contents are whatever the aborted pulse left.
- States: IDLE, DRIVE, SETTLE, VERIFY.
- IDLE:
  - wr_ready=1.
  - On accept, register wr_data and wr_mask, load counter=PULSE_CYCLES-1, and go to DRIVE.
  - wr_req without ready is ignored. There is no queueing, and the requester must hold its data until accepted.
- DRIVE:
  - latch_en=1, latch_set=data&mask, latch_reset=~data&mask.
  - Lasts exactly PULSE_CYCLES clocks.
  - At the end, go to SETTLE with counter=SETTLE_CYCLES-1, or to VERIFY if SETTLE_CYCLES=0.
- SETTLE:
  - latch_en=0, set=reset=0.
  - Lasts exactly SETTLE_CYCLES clocks, then go to VERIFY.
- VERIFY:
  - One clock, all latch outputs 0.
  - Per bit, fail[i] = mask[i] & ((latch_q[i]!=data[i]) | (latch_q[i]==latch_notq[i])).
  - At the end edge, register done=1, err=|fail, err_bits=fail, and go to IDLE.
- Completion and back-to-back:
  - done is high for exactly the first IDLE cycle, together with wr_ready=1.
  - err and err_bits hold their value until the next done.
  - A new accept in that same cycle is legal, so back-to-back writes are supported.
- Latency (P=PULSE_CYCLES, S=SETTLE_CYCLES):
  - The accept edge is cycle 0.
  - DRIVE occupies cycles 1..P, SETTLE occupies P+1..P+S, VERIFY occupies P+S+1.
  - done arrives in cycle P+S+2.
  - Maximum throughput is one write per P+S+2 cycles.
- Invariants:
  - latch_set & latch_reset == 0 in every cycle, including during and after reset.
  - latch_en=0 whenever state != DRIVE.
  - Unmasked bits never receive set or reset.
  - mask=0 is still a full transaction, with no pulses and err=0.
- Counter: $clog2(max(P,S,1)+1) bits, counting down, with no wrap. Reaching 0 triggers the transition.
- All outputs are registered or decoded from the state register only; no combinational path from latch_q to any output.

Decomposition:
- Package sr_writer_pkg holds:
  - the state encoding (IDLE=2'b00, DRIVE=2'b01, SETTLE=2'b10, VERIFY=2'b11);
  - the counter-width function;
  - elaboration checks: PULSE_CYCLES>=1, WIDTH>=1.
- One sub-module, sr_pulse_timer: loadable down-counter with a load value input, a load strobe, and a zero flag, reset asynchronously by rst_n.
- The bench instantiates WIDTH enabled SR latches (NAND-based) as the load.

Test Plan:
1. Reset: pulse rst_n=0 during DRIVE cycle 1 -> latch_en/set/reset drop to 0 immediately (no clock needed). After release wr_ready=1 and done never fires for the aborted write.
2. Latch bank at 00; write data=8'hA5, mask=8'hFF (defaults) -> latch_set=A5, latch_reset=5A, en=1 in cycles 1-2; SETTLE in cycle 3; done=1 in cycle 5 with err=0, err_bits=00; latch Q=A5.
3. Latch bank at A5; write data=8'hFF, mask=8'h0F -> set=0F, reset=00; Q=AF; err=0. A second write with mask=00 -> no pulses, done at cycle 5, Q unchanged.
4. Force latch_q[3]=0 (stuck-at); write data=8'h08, mask=FF -> err=1, err_bits=08. Separately force q[0]=notq[0]=1 -> err_bits bit 0 set.
5. Hold wr_req=1 with changing wr_data -> values presented while wr_ready=0 are never accepted; accepts occur every 5 cycles with done and accept coincident. An assertion checks set&reset==0 in every cycle.
6. SETTLE_CYCLES=0, PULSE_CYCLES=1 -> no SETTLE state; done arrives in cycle 3 after the accept edge.

Source files
------------

// File: rtl/sr_writer_pkg.sv
// Shared types and elaboration helpers for the SR latch write controller.
package sr_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DRIVE  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_VERIFY = 2'b11
    } state_e;

    // Down-counter width able to hold max(pulse, settle, 1).
    function automatic int unsigned cnt_width(input int unsigned pulse,
                                              input int unsigned settle);
        int unsigned m;
        m = (pulse > settle) ? pulse : settle;
        if (m < 1) begin
            m = 1;
        end
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned pulse);
        return (width >= 1) && (pulse >= 1);
    endfunction

endpackage

// File: rtl/sr_latch_writer_timer.sv
// Loadable down-counter that stops at zero; zero_o flags the last cycle of a phase.
module sr_pulse_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_writer.sv
// Write controller for a bank of gated NAND SR latches: pulse, settle, read back and verify.
module sr_latch_writer
    import sr_writer_pkg::*;
#(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned PULSE_CYCLES  = 2,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [WIDTH-1:0] wr_mask,
    output logic             wr_ready,
    output logic             latch_en,
    output logic [WIDTH-1:0] latch_set,
    output logic [WIDTH-1:0] latch_reset,
    input  logic [WIDTH-1:0] latch_q,
    input  logic [WIDTH-1:0] latch_notq,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] err_bits
);

    localparam int unsigned CNT_W = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD =
        CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);

    if (!params_ok(WIDTH, PULSE_CYCLES)) begin : g_param_check
        $error("sr_latch_writer: WIDTH and PULSE_CYCLES must both be >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;

    logic             wr_ready_q, wr_ready_d;
    logic             latch_en_q, latch_en_d;
    logic [WIDTH-1:0] latch_set_q, latch_set_d;
    logic [WIDTH-1:0] latch_reset_q, latch_reset_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_bits_q, err_bits_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic [WIDTH-1:0] fail;

    sr_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // A masked bit fails if Q disagrees with the data or Q/notQ are not complementary.
    always_comb begin
        fail = mask_q & ((latch_q ^ data_q) | ~(latch_q ^ latch_notq));
    end

    // Next state, captured operands and registered output values.
    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        mask_d        = mask_q;
        tmr_load      = 1'b0;
        tmr_val       = PULSE_LOAD;
        done_d        = 1'b0;
        err_d         = err_q;
        err_bits_d    = err_bits_q;
        wr_ready_d    = 1'b0;
        latch_en_d    = 1'b0;
        latch_set_d   = '0;
        latch_reset_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    data_d   = wr_data;
                    mask_d   = wr_mask;
                    tmr_load = 1'b1;
                    tmr_val  = PULSE_LOAD;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (tmr_zero) begin
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_VERIFY;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = SETTLE_LOAD;
                        state_d  = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (tmr_zero) begin
                    state_d = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                done_d     = 1'b1;
                err_d      = |fail;
                err_bits_d = fail;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they are valid from the first cycle.
        wr_ready_d = (state_d == ST_IDLE);
        if (state_d == ST_DRIVE) begin
            latch_en_d    = 1'b1;
            latch_set_d   = data_d & mask_d;
            latch_reset_d = ~data_d & mask_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            data_q        <= '0;
            mask_q        <= '0;
            wr_ready_q    <= 1'b1;
            latch_en_q    <= 1'b0;
            latch_set_q   <= '0;
            latch_reset_q <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_bits_q    <= '0;
        end else begin
            state_q       <= state_d;
            data_q        <= data_d;
            mask_q        <= mask_d;
            wr_ready_q    <= wr_ready_d;
            latch_en_q    <= latch_en_d;
            latch_set_q   <= latch_set_d;
            latch_reset_q <= latch_reset_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_bits_q    <= err_bits_d;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign latch_en    = latch_en_q;
    assign latch_set   = latch_set_q;
    assign latch_reset = latch_reset_q;
    assign done        = done_q;
    assign err         = err_q;
    assign err_bits    = err_bits_q;

endmodule

// File: tb/tb_sr_latch_writer.sv
// Directed bench for sr_latch_writer driving behavioural gated SR latch banks.
module tb_sr_latch_writer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Default configuration (P=2, S=1)
    logic       wr_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] wr_mask = 8'h00;
    logic       wr_ready, latch_en, done, err;
    logic [7:0] latch_set, latch_reset, latch_q, latch_notq, err_bits;

    // Fast configuration (P=1, S=0)
    logic       f_wr_req = 1'b0;
    logic [7:0] f_wr_data = 8'h00;
    logic [7:0] f_wr_mask = 8'h00;
    logic       f_wr_ready, f_latch_en, f_done, f_err;
    logic [7:0] f_latch_set, f_latch_reset, f_latch_q, f_latch_notq, f_err_bits;

    // Latch bank state plus fault injection (stuck-at-0 on Q, stuck-at-1 on notQ)
    logic [7:0] q_store = 8'h00;
    logic [7:0] fq_store = 8'h00;
    logic [7:0] sa0_q = 8'h00;
    logic [7:0] sa1_nq = 8'h00;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    sr_latch_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_data(wr_data), .wr_mask(wr_mask), .wr_ready(wr_ready),
        .latch_en(latch_en), .latch_set(latch_set), .latch_reset(latch_reset),
        .latch_q(latch_q), .latch_notq(latch_notq),
        .done(done), .err(err), .err_bits(err_bits)
    );

    sr_latch_writer #(.WIDTH(8), .PULSE_CYCLES(1), .SETTLE_CYCLES(0)) dut_fast (
        .clk(clk), .rst_n(rst_n),
        .wr_req(f_wr_req), .wr_data(f_wr_data), .wr_mask(f_wr_mask), .wr_ready(f_wr_ready),
        .latch_en(f_latch_en), .latch_set(f_latch_set), .latch_reset(f_latch_reset),
        .latch_q(f_latch_q), .latch_notq(f_latch_notq),
        .done(f_done), .err(f_err), .err_bits(f_err_bits)
    );

    // NAND SR latch with gate: S'=~(en&s), R'=~(en&r); stores while gate is low.
    always @(posedge clk) begin
        if (latch_en)   q_store  <= (q_store  | latch_set)   & ~latch_reset;
        if (f_latch_en) fq_store <= (fq_store | f_latch_set) & ~f_latch_reset;
    end
    assign latch_q      = q_store & ~sa0_q;
    assign latch_notq   = ~q_store | sa1_nq;
    assign f_latch_q    = fq_store;
    assign f_latch_notq = ~fq_store;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Set and reset must never be active together on any bit.
    always @(negedge clk) begin
        n_cmp++;
        assert (((latch_set & latch_reset) | (f_latch_set & f_latch_reset)) === 8'h00) else begin
            n_bad++;
            $error("FAIL set_and_reset: observed %0h/%0h expected 0",
                   latch_set & latch_reset, f_latch_set & f_latch_reset);
        end
    end

    // One write on the default DUT, called at a negedge with wr_ready high.
    task automatic run_write(input logic [7:0] d, input logic [7:0] m, input logic [7:0] exp_bits);
        logic [7:0] s;
        logic [7:0] r;
        int cyc;
        s = d & m;
        r = ~d & m;
        wr_req = 1'b1; wr_data = d; wr_mask = m;
        @(negedge clk);
        wr_req = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            chk("wr_en",    latch_en,    (cyc <= 2) ? 1'b1 : 1'b0);
            chk("wr_set",   latch_set,   (cyc <= 2) ? s : 8'h00);
            chk("wr_reset", latch_reset, (cyc <= 2) ? r : 8'h00);
            chk("wr_busy",  wr_ready,    1'b0);
            @(negedge clk);
            cyc++;
        end
        chk("wr_latency",  cyc,      5);
        chk("wr_ready_dn", wr_ready, 1'b1);
        chk("wr_err",      err,      |exp_bits);
        chk("wr_err_bits", err_bits, exp_bits);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int last_acc;
        int n_acc;
        bit have_pend;
        logic [7:0] pend;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_en",       latch_en,    1'b0);
        chk("rst_set",      latch_set,   8'h00);
        chk("rst_reset",    latch_reset, 8'h00);
        chk("rst_done",     done,        1'b0);
        chk("rst_err",      err,         1'b0);
        chk("rst_err_bits", err_bits,    8'h00);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", wr_ready, 1'b1);

        // Reset asserted in DRIVE cycle 1 kills the pulse without a clock
        wr_req = 1'b1; wr_data = 8'h3C; wr_mask = 8'hFF;
        @(negedge clk);
        wr_req = 1'b0;
        chk("abort_en_pre",  latch_en,  1'b1);
        chk("abort_set_pre", latch_set, 8'h3C);
        rst_n = 1'b0;
        #1;
        chk("abort_en",    latch_en,    1'b0);
        chk("abort_set",   latch_set,   8'h00);
        chk("abort_reset", latch_reset, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        chk("abort_ready", wr_ready, 1'b1);
        chk("abort_bank",  latch_q,  8'h00);

        // Full-mask write into an empty bank
        run_write(8'hA5, 8'hFF, 8'h00);
        chk("a5_bank", latch_q, 8'hA5);

        // Back-to-back partial mask, then an empty mask
        run_write(8'hFF, 8'h0F, 8'h00);
        chk("mask0f_bank", latch_q, 8'hAF);
        run_write(8'h00, 8'h00, 8'h00);
        chk("mask00_bank", latch_q, 8'hAF);

        // Stuck-at-0 on Q[3]
        sa0_q = 8'h08;
        run_write(8'h08, 8'hFF, 8'h08);
        repeat (2) @(negedge clk);
        chk("hold_done",     done,     1'b0);
        chk("hold_err",      err,      1'b1);
        chk("hold_err_bits", err_bits, 8'h08);
        sa0_q = 8'h00;

        // Q[0] and notQ[0] both high
        sa1_nq = 8'h01;
        run_write(8'h01, 8'hFF, 8'h01);
        sa1_nq = 8'h00;
        @(negedge clk);

        // Continuous request with changing data: only values seen with ready are taken
        last_acc = -1; n_acc = 0; have_pend = 1'b0; pend = 8'h00;
        wr_req = 1'b1; wr_mask = 8'hFF;
        for (int k = 0; k < 22; k++) begin
            wr_data = 8'(k * 37 + 11);
            if (have_pend) begin
                chk("stream_set", latch_set, pend);
                have_pend = 1'b0;
            end
            if (wr_ready) begin
                if (last_acc >= 0) begin
                    chk("stream_interval", k - last_acc, 5);
                    chk("stream_done",     done,         1'b1);
                    chk("stream_err",      err,          1'b0);
                end
                pend = wr_data; have_pend = 1'b1; last_acc = k; n_acc++;
            end
            @(negedge clk);
        end
        wr_req = 1'b0;
        chk("stream_accepts", n_acc, 5);
        repeat (6) @(negedge clk);

        // No-settle configuration: done two cycles after the single drive cycle
        f_wr_req = 1'b1; f_wr_data = 8'hA5; f_wr_mask = 8'hFF;
        @(negedge clk);
        f_wr_req = 1'b0;
        chk("fast_en_c1",    f_latch_en,    1'b1);
        chk("fast_set_c1",   f_latch_set,   8'hA5);
        chk("fast_reset_c1", f_latch_reset, 8'h5A);
        @(negedge clk);
        chk("fast_en_c2",   f_latch_en, 1'b0);
        chk("fast_done_c2", f_done,     1'b0);
        @(negedge clk);
        chk("fast_done_c3",  f_done,     1'b1);
        chk("fast_err_c3",   f_err,      1'b0);
        chk("fast_ready_c3", f_wr_ready, 1'b1);
        chk("fast_bank",     f_latch_q,  8'hA5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
